audio_fifo_writer: RTL and testbench

Write-side producer for the 32-bit sample FIFO that the Nios II subsystem drains through its PIO q/rdempty/rdfull/rdreq ports. Accepts a stream of signed mono-channel audio samples tagged left/right and pairs them into stereo words {left, right}. Pushes the words through a small staging buffer into the FIFO write port (data/wrreq/wrfull). Reports drops and channel-sync errors to status outputs.

---
 rtl/audio_fifo_writer_pkg.sv | 29 ++
 rtl/audio_fifo_writer_if.sv | 25 ++
 rtl/audio_fifo_writer_stage.sv | 54 +++++
 rtl/audio_fifo_writer.sv | 146 ++++++++++++++
 tb/tb_audio_fifo_writer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_fifo_writer_pkg.sv
// Shared types and helpers for the audio FIFO writer: FSM states, word geometry
// and the sign-extending stereo packer.
package audio_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_L = 2'd1,
    WAIT_R = 2'd2
  } afw_state_e;

  localparam int WORD_W = 32;
  localparam int CH_W   = 16;

  // Shift the sample's sign bit up to bit 15, then arithmetic-shift back down.
  function automatic logic [CH_W-1:0] sext_sample(input logic [CH_W-1:0] raw,
                                                  input int unsigned     sw);
    logic [CH_W-1:0] shifted;
    shifted = raw << (CH_W - sw);
    return $signed(shifted) >>> (CH_W - sw);
  endfunction

  // The left channel arrives already extended; the right channel is raw.
  function automatic logic [WORD_W-1:0] pack_word(input logic [CH_W-1:0] left_ext,
                                                  input logic [CH_W-1:0] right_raw,
                                                  input int unsigned     sw);
    return {left_ext, sext_sample(right_raw, sw)};
  endfunction

endpackage

// File: rtl/audio_fifo_writer_if.sv
// Sample-stream input plus FIFO write port of the audio FIFO writer.
// The master modport is the writer; the slave modport is the source/FIFO side.
interface audio_fifo_writer_if #(
  parameter int SAMPLE_W = 16
) ();
  import audio_fifo_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_is_left;
  logic [WORD_W-1:0]   fifo_data;
  logic                fifo_wrreq;
  logic                fifo_wrfull;

  modport master (
    input  sample_valid, sample_data, sample_is_left, fifo_wrfull,
    output fifo_data, fifo_wrreq
  );

  modport slave (
    output sample_valid, sample_data, sample_is_left, fifo_wrfull,
    input  fifo_data, fifo_wrreq
  );

endinterface

// File: rtl/audio_fifo_writer_stage.sv
// Small synchronous staging FIFO between the pairing FSM and the external FIFO.
// The caller must only push when not full (or popping) and only pop when not empty.
module audio_stage_fifo
  import audio_fifo_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int PTR_W     = $clog2(BUF_DEPTH),
  parameter int LVL_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  logic [WORD_W-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;

  // Storage, power-of-two wrapping pointers and true occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == LVL_W'(BUF_DEPTH));

endmodule

// File: rtl/audio_fifo_writer.sv
// Pairs left/right mono samples into {left, right} stereo words, stages them and
// writes them into the sample FIFO, counting drops and channel-order errors.
module audio_fifo_writer
  import audio_fifo_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        enable,
  input  logic                        clear_status,
  audio_fifo_writer_if.master         bus,
  output logic [CNT_W-1:0]            drop_count,
  output logic [CNT_W-1:0]            sync_err_count,
  output logic                        overrun,
  output logic [$clog2(BUF_DEPTH):0]  buf_level
);

  localparam int LVL_W = $clog2(BUF_DEPTH) + 1;

  afw_state_e        state_r;
  logic [CH_W-1:0]   left_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  sync_cnt_r;
  logic              overrun_r;

  logic [CH_W-1:0]   sample_ext_s;
  logic [WORD_W-1:0] word_s;
  logic              capture_s;
  logic              pair_done_s;
  logic              sync_err_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              full_s;
  logic [WORD_W-1:0] head_s;
  logic [LVL_W-1:0]  level_s;
  logic [CNT_W-1:0]  drop_base_s;
  logic [CNT_W-1:0]  drop_next_s;
  logic [CNT_W-1:0]  sync_base_s;
  logic [CNT_W-1:0]  sync_next_s;

  assign sample_ext_s = sext_sample(CH_W'(bus.sample_data), SAMPLE_W);
  assign word_s       = pack_word(left_r, CH_W'(bus.sample_data), SAMPLE_W);

  // Samples are ignored in IDLE and whenever capture is disabled.
  assign capture_s   = enable && bus.sample_valid && (state_r != IDLE);
  assign pair_done_s = capture_s && (state_r == WAIT_R) && !bus.sample_is_left;
  assign sync_err_s  = capture_s &&
                       (((state_r == WAIT_L) && !bus.sample_is_left) ||
                        ((state_r == WAIT_R) &&  bus.sample_is_left));

  // A completed pair always fits when the head leaves in the same cycle.
  assign pop_s  = bus.fifo_wrreq;
  assign push_s = pair_done_s && (!full_s || pop_s);
  assign drop_s = pair_done_s && full_s && !pop_s;

  audio_stage_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_stage (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push_s),
    .push_data (word_s),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s),
    .full      (full_s)
  );

  assign bus.fifo_wrreq = (level_s != '0) && !bus.fifo_wrfull;
  assign bus.fifo_data  = head_s;

  // Pairing FSM; dropping enable flushes a held left sample.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
      left_r  <= '0;
    end else if (!enable) begin
      state_r <= IDLE;
      left_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= WAIT_L;
        end
        WAIT_L: begin
          if (bus.sample_valid && bus.sample_is_left) begin
            left_r  <= sample_ext_s;
            state_r <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (bus.sample_valid) begin
            if (bus.sample_is_left) begin
              left_r <= sample_ext_s;
            end else begin
              state_r <= WAIT_L;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          left_r  <= '0;
        end
      endcase
    end
  end

  // Clear first, then apply this cycle's event, saturating at all-ones.
  always_comb begin
    drop_base_s = clear_status ? '0 : drop_cnt_r;
    sync_base_s = clear_status ? '0 : sync_cnt_r;
    if (drop_s && (drop_base_s != '1)) begin
      drop_next_s = drop_base_s + CNT_W'(1);
    end else begin
      drop_next_s = drop_base_s;
    end
    if (sync_err_s && (sync_base_s != '1)) begin
      sync_next_s = sync_base_s + CNT_W'(1);
    end else begin
      sync_next_s = sync_base_s;
    end
  end

  // Status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      drop_cnt_r <= '0;
      sync_cnt_r <= '0;
      overrun_r  <= 1'b0;
    end else begin
      drop_cnt_r <= drop_next_s;
      sync_cnt_r <= sync_next_s;
      overrun_r  <= (overrun_r && !clear_status) || drop_s;
    end
  end

  assign drop_count     = drop_cnt_r;
  assign sync_err_count = sync_cnt_r;
  assign overrun        = overrun_r;
  assign buf_level      = level_s;

endmodule

// File: tb/tb_audio_fifo_writer.sv
// Scoreboard bench for audio_fifo_writer: a 16-bit instance for the main
// scenarios and a 12-bit instance for sign extension.
module tb_audio_fifo_writer;

  logic clk;
  logic rst_n;
  logic enable;
  logic enable12;
  logic clear_status;
  logic clear12;

  logic [15:0] drop16, sync16, drop12, sync12;
  logic        ovr16, ovr12;
  logic [2:0]  lvl16, lvl12;

  int n_checks;
  int n_fail;

  logic [31:0] sb16[$];
  logic [31:0] sb12[$];

  audio_fifo_writer_if #(.SAMPLE_W(16)) bus16 ();
  audio_fifo_writer_if #(.SAMPLE_W(12)) bus12 ();

  audio_fifo_writer #(.SAMPLE_W(16), .BUF_DEPTH(4), .CNT_W(16)) dut16 (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (enable),
    .clear_status   (clear_status),
    .bus            (bus16),
    .drop_count     (drop16),
    .sync_err_count (sync16),
    .overrun        (ovr16),
    .buf_level      (lvl16)
  );

  audio_fifo_writer #(.SAMPLE_W(12), .BUF_DEPTH(4), .CNT_W(16)) dut12 (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (enable12),
    .clear_status   (clear12),
    .bus            (bus12),
    .drop_count     (drop12),
    .sync_err_count (sync12),
    .overrun        (ovr12),
    .buf_level      (lvl12)
  );

  always #5 clk = ~clk;

  // One clock: scoreboard both write ports at the falling edge, return at posedge+1.
  task automatic step();
    logic [31:0] exp_w;
    @(negedge clk);
    if (bus16.fifo_wrreq) begin
      n_checks++;
      if (bus16.fifo_wrfull !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_while_full16: wrfull=%b required 0 when wrreq=1", bus16.fifo_wrfull);
      end
      n_checks++;
      if (sb16.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write16: got %h required no write", bus16.fifo_data);
      end else begin
        exp_w = sb16.pop_front();
        if (bus16.fifo_data !== exp_w) begin
          n_fail++;
          $display("FAIL fifo_data16: got %h required %h", bus16.fifo_data, exp_w);
        end
      end
    end
    if (bus12.fifo_wrreq) begin
      n_checks++;
      if (sb12.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write12: got %h required no write", bus12.fifo_data);
      end else begin
        exp_w = sb12.pop_front();
        if (bus12.fifo_data !== exp_w) begin
          n_fail++;
          $display("FAIL fifo_data12: got %h required %h", bus12.fifo_data, exp_w);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic is_left, input logic [15:0] d);
    bus16.sample_valid   = 1'b1;
    bus16.sample_is_left = is_left;
    bus16.sample_data    = d;
    step();
    bus16.sample_valid   = 1'b0;
  endtask

  task automatic send_pair16(input logic [15:0] l, input logic [15:0] r, input bit expect_push);
    send16(1'b1, l);
    if (expect_push) sb16.push_back({l, r});
    send16(1'b0, r);
  endtask

  task automatic clear_pulse();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks += 6;
    if (bus16.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b required 0", bus16.fifo_wrreq); end
    if (bus16.fifo_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", bus16.fifo_data); end
    if (drop16 !== 16'h0) begin n_fail++; $display("FAIL rst_drop: got %h required 0", drop16); end
    if (sync16 !== 16'h0) begin n_fail++; $display("FAIL rst_sync: got %h required 0", sync16); end
    if (ovr16 !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b required 0", ovr16); end
    if (lvl16 !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", lvl16); end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    enable   = 1'b1;
    enable12 = 1'b1;
    step();
  endtask

  task automatic test_basic_pair();
    send_pair16(16'h1234, 16'hABCD, 1'b1);
    repeat (3) step();
    n_checks += 4;
    if (sb16.size() != 0) begin n_fail++; $display("FAIL basic_missing: got %0d pending required 0", sb16.size()); end
    if (drop16 !== 16'h0) begin n_fail++; $display("FAIL basic_drop: got %h required 0", drop16); end
    if (sync16 !== 16'h0) begin n_fail++; $display("FAIL basic_sync: got %h required 0", sync16); end
    if (lvl16 !== 3'd0) begin n_fail++; $display("FAIL basic_level: got %0d required 0", lvl16); end
  endtask

  task automatic test_sext12();
    bus12.sample_valid   = 1'b1;
    bus12.sample_is_left = 1'b1;
    bus12.sample_data    = 12'h800;
    step();
    bus12.sample_is_left = 1'b0;
    bus12.sample_data    = 12'h7FF;
    sb12.push_back(32'hF80007FF);
    step();
    bus12.sample_valid   = 1'b0;
    repeat (3) step();
    n_checks++;
    if (sb12.size() != 0) begin n_fail++; $display("FAIL sext12_missing: got %0d pending required 0", sb12.size()); end
  endtask

  task automatic test_sync_err();
    clear_pulse();
    send16(1'b0, 16'h0009);
    send16(1'b1, 16'h0001);
    send16(1'b1, 16'h0002);
    sb16.push_back(32'h00020003);
    send16(1'b0, 16'h0003);
    repeat (3) step();
    n_checks += 2;
    if (sync16 !== 16'd2) begin n_fail++; $display("FAIL sync_count: got %0d required 2", sync16); end
    if (sb16.size() != 0) begin n_fail++; $display("FAIL sync_missing: got %0d pending required 0", sb16.size()); end
  endtask

  task automatic test_full_drop();
    clear_pulse();
    bus16.fifo_wrfull = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_pair16(16'h1000 + 16'(i), 16'h2000 + 16'(i), i < 4);
    end
    n_checks += 3;
    if (lvl16 !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d required 4", lvl16); end
    if (drop16 !== 16'd2) begin n_fail++; $display("FAIL full_drop: got %0d required 2", drop16); end
    if (ovr16 !== 1'b1) begin n_fail++; $display("FAIL full_overrun: got %b required 1", ovr16); end
    bus16.fifo_wrfull = 1'b0;
    repeat (6) step();
    n_checks += 2;
    if (lvl16 !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d required 0", lvl16); end
    if (sb16.size() != 0) begin n_fail++; $display("FAIL drain_missing: got %0d pending required 0", sb16.size()); end
  endtask

  task automatic test_full_pop_same_cycle();
    clear_pulse();
    bus16.fifo_wrfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pair16(16'h3000 + 16'(i), 16'h4000 + 16'(i), 1'b1);
    end
    send16(1'b1, 16'h3004);
    bus16.fifo_wrfull = 1'b0;
    sb16.push_back(32'h30044004);
    send16(1'b0, 16'h4004);
    n_checks += 3;
    if (lvl16 !== 3'd4) begin n_fail++; $display("FAIL same_cycle_level: got %0d required 4", lvl16); end
    if (drop16 !== 16'd0) begin n_fail++; $display("FAIL same_cycle_drop: got %0d required 0", drop16); end
    if (ovr16 !== 1'b0) begin n_fail++; $display("FAIL same_cycle_overrun: got %b required 0", ovr16); end
    repeat (6) step();
    n_checks += 2;
    if (lvl16 !== 3'd0) begin n_fail++; $display("FAIL same_cycle_drain: got %0d required 0", lvl16); end
    if (sb16.size() != 0) begin n_fail++; $display("FAIL same_cycle_missing: got %0d pending required 0", sb16.size()); end
  endtask

  task automatic test_enable_flush();
    clear_pulse();
    send16(1'b1, 16'h5555);
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    send16(1'b0, 16'h6666);
    send_pair16(16'h0007, 16'h0008, 1'b1);
    repeat (3) step();
    n_checks += 3;
    if (sync16 !== 16'd1) begin n_fail++; $display("FAIL flush_sync: got %0d required 1", sync16); end
    if (drop16 !== 16'd0) begin n_fail++; $display("FAIL flush_drop: got %0d required 0", drop16); end
    if (sb16.size() != 0) begin n_fail++; $display("FAIL flush_missing: got %0d pending required 0", sb16.size()); end
  endtask

  task automatic test_clear_with_drop();
    clear_pulse();
    bus16.fifo_wrfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pair16(16'h5000 + 16'(i), 16'h6000 + 16'(i), 1'b1);
    end
    send_pair16(16'h5100, 16'h6100, 1'b0);
    n_checks++;
    if (drop16 !== 16'd1) begin n_fail++; $display("FAIL pre_clear_drop: got %0d required 1", drop16); end
    send16(1'b1, 16'h5200);
    clear_status = 1'b1;
    send16(1'b0, 16'h6200);
    clear_status = 1'b0;
    n_checks += 2;
    if (drop16 !== 16'd1) begin n_fail++; $display("FAIL clear_drop_same: got %0d required 1", drop16); end
    if (ovr16 !== 1'b1) begin n_fail++; $display("FAIL clear_ovr_same: got %b required 1", ovr16); end
    clear_pulse();
    n_checks += 2;
    if (drop16 !== 16'd0) begin n_fail++; $display("FAIL clear_drop: got %0d required 0", drop16); end
    if (ovr16 !== 1'b0) begin n_fail++; $display("FAIL clear_ovr: got %b required 0", ovr16); end
  endtask

  task automatic test_reset_mid_drain();
    send_pair16(16'h7000, 16'h7001, 1'b0);
    send16(1'b0, 16'h0BAD);
    n_checks += 3;
    if (drop16 !== 16'd1) begin n_fail++; $display("FAIL pre_rst_drop: got %0d required 1", drop16); end
    if (sync16 !== 16'd1) begin n_fail++; $display("FAIL pre_rst_sync: got %0d required 1", sync16); end
    if (ovr16 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_ovr: got %b required 1", ovr16); end
    bus16.fifo_wrfull = 1'b0;
    step();
    step();
    n_checks++;
    if (lvl16 !== 3'd2) begin n_fail++; $display("FAIL mid_drain_level: got %0d required 2", lvl16); end
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (bus16.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wrreq: got %b required 0", bus16.fifo_wrreq); end
    if (bus16.fifo_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h required 0", bus16.fifo_data); end
    if (lvl16 !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d required 0", lvl16); end
    if (drop16 !== 16'h0) begin n_fail++; $display("FAIL mid_rst_drop: got %h required 0", drop16); end
    if (sync16 !== 16'h0) begin n_fail++; $display("FAIL mid_rst_sync: got %h required 0", sync16); end
    if (ovr16 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovr: got %b required 0", ovr16); end
    sb16.delete();
    #2;
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    clk                  = 1'b0;
    rst_n                = 1'b0;
    enable               = 1'b0;
    enable12             = 1'b0;
    clear_status         = 1'b0;
    clear12              = 1'b0;
    bus16.sample_valid   = 1'b0;
    bus16.sample_data    = 16'h0;
    bus16.sample_is_left = 1'b0;
    bus16.fifo_wrfull    = 1'b0;
    bus12.sample_valid   = 1'b0;
    bus12.sample_data    = 12'h0;
    bus12.sample_is_left = 1'b0;
    bus12.fifo_wrfull    = 1'b0;

    test_reset();
    test_basic_pair();
    test_sext12();
    test_sync_err();
    test_full_drop();
    test_full_pop_same_cycle();
    test_enable_flush();
    test_clear_with_drop();
    test_reset_mid_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
